// File: rtl/imm_ext_pipe.sv
// Immediate-extension stage: zero/sign/upper/branch-offset extension feeding a
// registered output with a 2-entry skid buffer behind a valid/ready handshake.
module imm_ext_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [IN_W-1:0]  entrada,
  input  logic [1:0]       modo,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [OUT_W-1:0] salida,
  output logic             valid_out,
  input  logic             ready_out
);

  localparam int unsigned EXT_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext_c;
  logic [OUT_W-1:0] ext_c;
  logic             accept_c;
  logic             drain_c;

  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;

  logic             valid_out_nxt;
  logic [OUT_W-1:0] salida_nxt;
  logic             skid_valid_nxt;
  logic [OUT_W-1:0] skid_data_nxt;
  logic             ready_in_nxt;

  // Extension ahead of the registers; branch offset wraps at OUT_W bits.
  always_comb begin
    sext_c = {{EXT_W{entrada[IN_W-1]}}, entrada};
    ext_c  = '0;
    case (modo)
      2'b00:   ext_c = {{EXT_W{1'b0}}, entrada};
      2'b01:   ext_c = sext_c;
      2'b10:   ext_c = {entrada, {EXT_W{1'b0}}};
      default: ext_c = sext_c << 2;
    endcase
  end

  assign accept_c = valid_in & ready_in;
  assign drain_c  = valid_out & ready_out;

  // Next-state for output and skid registers; flush overrides everything.
  always_comb begin
    valid_out_nxt  = valid_out;
    salida_nxt     = salida;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    if (flush) begin
      valid_out_nxt  = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (drain_c) begin
      if (skid_valid) begin
        salida_nxt     = skid_data;
        valid_out_nxt  = 1'b1;
        skid_valid_nxt = 1'b0;
      end else if (accept_c) begin
        salida_nxt    = ext_c;
        valid_out_nxt = 1'b1;
      end else begin
        valid_out_nxt = 1'b0;
      end
    end else if (accept_c) begin
      if (!valid_out) begin
        salida_nxt    = ext_c;
        valid_out_nxt = 1'b1;
      end else begin
        skid_data_nxt  = ext_c;
        skid_valid_nxt = 1'b1;
      end
    end
    ready_in_nxt = ~skid_valid_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out  <= 1'b0;
      salida     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready_in   <= 1'b1;
    end else begin
      valid_out  <= valid_out_nxt;
      salida     <= salida_nxt;
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
      ready_in   <= ready_in_nxt;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed and randomised checks of imm_ext_pipe at 16/32 and 8/16 widths.
module tb_imm_ext_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [15:0] entrada;
  logic [1:0]  modo;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] salida;
  logic        valid_out;
  logic        ready_out;

  logic [7:0]  e8;
  logic [1:0]  m8;
  logic        v8;
  logic        ri8;
  logic [15:0] salida8;
  logic        vo8;
  logic        ro8;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  logic        hold;
  logic        acc;
  logic        drn;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .entrada(entrada), .modo(modo),
    .valid_in(valid_in), .ready_in(ready_in), .salida(salida),
    .valid_out(valid_out), .ready_out(ready_out)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16)) u_dut8 (
    .clk(clk), .reset(reset), .flush(flush), .entrada(e8), .modo(m8),
    .valid_in(v8), .ready_in(ri8), .salida(salida8),
    .valid_out(vo8), .ready_out(ro8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference extension for the 16->32 instance.
  function automatic logic [31:0] ref_ext(input logic [15:0] e, input logic [1:0] m);
    logic [31:0] s;
    s = {{16{e[15]}}, e};
    case (m)
      2'b00:   return {16'h0000, e};
      2'b01:   return s;
      2'b10:   return {e, 16'h0000};
      default: return s * 32'd4;
    endcase
  endfunction

  logic [31:0] exp_modes [4] = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
  logic [15:0] exp_sweep [4] = '{16'h0080, 16'hFF80, 16'h8000, 16'hFE00};

  initial begin
    reset = 1'b1; flush = 1'b0; entrada = '0; modo = '0; valid_in = 1'b0; ready_out = 1'b0;
    e8 = '0; m8 = '0; v8 = 1'b0; ro8 = 1'b0;
    hold = 1'b0; acc = 1'b0; drn = 1'b0;

    // Reset state
    #12;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_salida", salida, 32'd0);
    chk("rst_ready_in", 32'(ready_in), 32'd1);
    chk("rst8_salida", 32'(salida8), 32'd0);
    reset = 1'b0;
    tick;

    // All four modes, streamed back to back
    ready_out = 1'b1; valid_in = 1'b1; entrada = 16'h8001;
    for (int i = 0; i < 4; i++) begin
      modo = 2'(i);
      tick;
      chk($sformatf("mode%0d_valid", i), 32'(valid_out), 32'd1);
      chk($sformatf("mode%0d_salida", i), salida, exp_modes[i]);
    end
    valid_in = 1'b0;
    tick;
    chk("mode_idle_valid", 32'(valid_out), 32'd0);

    // Backpressure: A to output, B to skid, C held by producer
    modo = 2'b00; valid_in = 1'b1; entrada = 16'h0001;
    tick;
    chk("bp_a_valid", 32'(valid_out), 32'd1);
    chk("bp_a_salida", salida, 32'h1);
    ready_out = 1'b0; entrada = 16'h0002;
    tick;
    chk("bp_b_hold_salida", salida, 32'h1);
    chk("bp_b_ready_in", 32'(ready_in), 32'd0);
    entrada = 16'h0003;
    tick;
    chk("bp_c_hold_salida", salida, 32'h1);
    chk("bp_c_ready_in", 32'(ready_in), 32'd0);
    chk("bp_c_valid", 32'(valid_out), 32'd1);
    ready_out = 1'b1;
    tick;
    chk("bp_out_b", salida, 32'h2);
    chk("bp_out_b_ready_in", 32'(ready_in), 32'd1);
    tick;
    chk("bp_out_c", salida, 32'h3);
    chk("bp_out_c_valid", 32'(valid_out), 32'd1);
    valid_in = 1'b0;
    tick;
    chk("bp_empty", 32'(valid_out), 32'd0);

    // Flush with output and skid full
    ready_out = 1'b0; valid_in = 1'b1; entrada = 16'h0010;
    tick;
    chk("fl_load_salida", salida, 32'h10);
    entrada = 16'h0020;
    tick;
    chk("fl_full_ready_in", 32'(ready_in), 32'd0);
    entrada = 16'h0030; flush = 1'b1;
    tick;
    chk("fl_valid_out", 32'(valid_out), 32'd0);
    chk("fl_ready_in", 32'(ready_in), 32'd1);
    flush = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    tick;
    chk("fl_no_ghost", 32'(valid_out), 32'd0);

    // Flush while an accept happens: the accepted word is discarded
    ready_out = 1'b0; valid_in = 1'b1; entrada = 16'h0040;
    tick;
    chk("fl2_load", 32'(valid_out), 32'd1);
    entrada = 16'h0050; flush = 1'b1;
    tick;
    chk("fl2_valid_out", 32'(valid_out), 32'd0);
    chk("fl2_ready_in", 32'(ready_in), 32'd1);
    flush = 1'b0; valid_in = 1'b0;
    tick;
    chk("fl2_no_ghost", 32'(valid_out), 32'd0);

    // Asynchronous reset mid-stream
    valid_in = 1'b1; entrada = 16'h8001; modo = 2'b01;
    tick;
    chk("ar_loaded", 32'(valid_out), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid_out", 32'(valid_out), 32'd0);
    chk("ar_salida", salida, 32'd0);
    chk("ar_ready_in", 32'(ready_in), 32'd1);
    reset = 1'b0;
    tick;
    chk("ar_first_accept_valid", 32'(valid_out), 32'd1);
    chk("ar_first_accept_salida", salida, 32'hFFFF8001);
    valid_in = 1'b0; ready_out = 1'b1;
    tick;
    tick;
    chk("ar_drained", 32'(valid_out), 32'd0);

    // Narrow instance 8 -> 16
    ro8 = 1'b1; v8 = 1'b1; e8 = 8'h80;
    for (int i = 0; i < 4; i++) begin
      m8 = 2'(i);
      tick;
      chk($sformatf("sweep_mode%0d", i), 32'(salida8), 32'(exp_sweep[i]));
    end
    v8 = 1'b0;
    tick;
    chk("sweep_idle", 32'(vo8), 32'd0);

    // Random valid_in / ready_out against a scoreboard
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      chk("rnd_valid_out", 32'(valid_out), 32'(q.size() > 0));
      chk("rnd_ready_in", 32'(ready_in), 32'(q.size() < 2));
      if (!hold) begin
        valid_in = ($urandom_range(0, 9) < 6);
        entrada  = 16'($urandom);
        modo     = 2'($urandom);
      end
      ready_out = ($urandom_range(0, 9) < 5);
      acc = valid_in && ready_in;
      drn = valid_out && ready_out;
      if (drn && q.size() > 0) begin
        chk("rnd_salida", salida, q[0]);
        void'(q.pop_front());
      end
      if (acc) q.push_back(ref_ext(entrada, modo));
      hold = valid_in && !acc;
      tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
